// File: rtl/instr_stream_writer.sv
// instr_stream_writer: encodes field-level RV32I requests into words and streams them into instruction memory through a FIFO
module instr_stream_writer #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              fmt,
  input  logic [6:0]              opc,
  input  logic [2:0]              f3,
  input  logic [6:0]              f7,
  input  logic [4:0]              rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [31:0]             imm,
  output logic                    mem_we,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [31:0]       fifo_q [DEPTH];
  logic [31:0]       fifo_d [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [31:0]       enc;
  logic              legal, accept, push, pop;
  always_comb begin
    case (fmt)
      3'd0:    enc = {f7, rs2, rs1, f3, rd, opc};
      3'd1:    enc = {imm[11:0], rs1, f3, rd, opc};
      3'd2:    enc = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      3'd3:    enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      3'd4:    enc = {imm[31:12], rd, opc};
      3'd5:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: enc = '0;
    endcase
  end
  assign legal     = fmt < 3'd6;
  assign in_ready  = (count_q != FULL) && !clear;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign mem_we    = count_q != '0;
  assign pop       = mem_we && mem_ready && !clear;
  assign mem_addr  = addr_q;
  assign mem_wdata = fifo_q[rptr_q];
  assign count     = count_q;
  assign err       = err_q;
  // clear wins over any push/pop in the same cycle; push is already blocked by in_ready
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = enc;
    wptr_d  = clear ? '0 : push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = clear ? '0 : pop ? rptr_q + 1'b1 : rptr_q;
    count_d = clear ? '0 : (push && !pop) ? count_q + 1'b1 : (!push && pop) ? count_q - 1'b1 : count_q;
    addr_d  = clear ? BASE_ADDR : pop ? addr_q + ADDR_W'(4) : addr_q;
    err_d   = !clear && accept && !legal;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  // storage needs no reset: mem_wdata is don't-care while the FIFO is empty
  always_ff @(posedge clk) fifo_q <= fifo_d;
endmodule

// File: tb/tb_instr_stream_writer.sv
// tb_instr_stream_writer: directed scoreboard bench for instr_stream_writer
module tb_instr_stream_writer;
  logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, mem_ready = 1'b1;
  logic [2:0]  fmt = '0, f3 = '0;
  logic [6:0]  opc = '0, f7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        in_ready, mem_we, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  count;
  int checks = 0, failures = 0, nwr = 0, n0;
  logic [31:0] wr_addr = '0;
  logic [63:0] q[$];
  logic [31:0] w[5];

  instr_stream_writer #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opc(opc), .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // every completed memory write must match the head of the scoreboard
  always @(negedge clk)
    if (!rst && mem_we && mem_ready) begin
      check("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        logic [63:0] e;
        e = q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
        check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
      end
      nwr++;
    end

  task automatic send(input bit legal, input logic [31:0] exp);
    int n = 0;
    bit ok;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    ok = in_ready;
    check("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    if (ok && legal) begin q.push_back({wr_addr, exp}); wr_addr += 4; end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (mem_we && n < 100) begin @(posedge clk); n++; end
    #1;
    check("drain_we", 64'(mem_we), 64'd0);
    check("drain_sb", 64'(q.size()), 64'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    q.delete();
    wr_addr = '0;
  endtask

  task automatic set_i(input logic [4:0] d, input logic [31:0] im);
    fmt = 3'd1; opc = 7'h13; f3 = 3'd0; rd = d; rs1 = 5'd0; imm = im;
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    // addi x1,x0,5 with single-cycle latency
    set_i(5'd1, 32'd5);
    send(1'b1, 32'h00500093);
    check("i_we", 64'(mem_we), 64'd1);
    check("i_addr", 64'(mem_addr), 64'd0);
    check("i_data", 64'(mem_wdata), 64'h00500093);
    drain();
    do_clear();
    // add then sw back-to-back
    fmt = 3'd0; opc = 7'h33; f3 = 3'd0; f7 = 7'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2;
    send(1'b1, 32'h002081B3);
    fmt = 3'd2; opc = 7'h23; f3 = 3'd2; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd8;
    send(1'b1, 32'h0020A423);
    drain();
    do_clear();
    // B, J, U immediate scrambling
    fmt = 3'd3; opc = 7'h63; f3 = 3'd0; rs1 = 5'd1; rs2 = 5'd2; imm = 32'hFFFFFFFC;
    send(1'b1, 32'hFE208EE3);
    fmt = 3'd5; opc = 7'h6F; rd = 5'd1; imm = 32'd8;
    send(1'b1, 32'h008000EF);
    fmt = 3'd4; opc = 7'h37; rd = 5'd5; imm = 32'h12345678;
    send(1'b1, 32'h123452B7);
    drain();
    do_clear();
    // backpressure: fill 4, fifth waits until a pop frees space
    mem_ready = 1'b0;
    n0 = nwr;
    for (int i = 0; i < 5; i++) w[i] = ((i + 1) << 20) | ((i + 1) << 7) | 32'h13;
    for (int i = 0; i < 4; i++) begin set_i(5'(i + 1), 32'(i + 1)); send(1'b1, w[i]); end
    check("bp_count", 64'(count), 64'd4);
    check("bp_ready", 64'(in_ready), 64'd0);
    set_i(5'd5, 32'd5);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_count", 64'(count), 64'd4);
    check("bp_hold_data", 64'(mem_wdata), 64'(w[0]));
    check("bp_hold_addr", 64'(mem_addr), 64'd0);
    mem_ready = 1'b1;
    send(1'b1, w[4]);
    drain();
    check("bp_writes", 64'(nwr - n0), 64'd5);
    do_clear();
    // illegal fmt between two legal pushes
    mem_ready = 1'b0;
    n0 = nwr;
    set_i(5'd7, 32'd1);
    send(1'b1, (32'd1 << 20) | (32'd7 << 7) | 32'h13);
    fmt = 3'd7;
    send(1'b0, 32'h0);
    check("ill_err", 64'(err), 64'd1);
    check("ill_count", 64'(count), 64'd1);
    check("ill_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    check("ill_err_clr", 64'(err), 64'd0);
    set_i(5'd8, 32'd2);
    send(1'b1, (32'd2 << 20) | (32'd8 << 7) | 32'h13);
    check("ill_count2", 64'(count), 64'd2);
    mem_ready = 1'b1;
    drain();
    check("ill_writes", 64'(nwr - n0), 64'd2);
    do_clear();
    // asynchronous reset mid-drain
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin set_i(5'(i + 1), 32'(i + 1)); send(1'b1, w[i]); end
    check("ar_count", 64'(count), 64'd3);
    mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("ar_we", 64'(mem_we), 64'd0);
    check("ar_addr", 64'(mem_addr), 64'd0);
    check("ar_count0", 64'(count), 64'd0);
    q.delete();
    wr_addr = '0;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    check("ar_ready", 64'(in_ready), 64'd1);
    // clear with a simultaneous request
    mem_ready = 1'b0;
    n0 = nwr;
    for (int i = 0; i < 2; i++) begin set_i(5'(i + 1), 32'(i + 1)); send(1'b1, w[i]); end
    check("cl_count", 64'(count), 64'd2);
    set_i(5'd9, 32'd9);
    in_valid = 1'b1;
    clear = 1'b1;
    #1;
    check("cl_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    q.delete();
    wr_addr = '0;
    check("cl_count0", 64'(count), 64'd0);
    check("cl_we", 64'(mem_we), 64'd0);
    check("cl_addr", 64'(mem_addr), 64'd0);
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cl_writes", 64'(nwr - n0), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
